spi_slave_regs: RTL and testbench
=================================

// Module: spi_slave_regs
// PURPOSE
//  SPI mode-0 target that terminates the team's 24-bit SPI master frame: ID byte, addr byte, data byte, MSB first.
//  ID 8'h64 = write, 8'h65 = read. Holds a small byte register file.
//  Oversamples ss/sck/mosi in the local clock domain; local logic gets write strobes and a side read port.
// PARAMETERS
//  SLAVE_IDW  8'h64  ID byte that selects a write frame
//  SLAVE_IDR  8'h65  ID byte that selects a read frame
//  DEPTH      16     number of 8-bit registers (addr 0..DEPTH-1, DEPTH<=255)
// PORTS
//  clock       in   1  system clock
//  n_reset     in   1  asynchronous, active-low reset
//  ss          in   1  slave select, active low, async to clock
//  sck         in   1  SPI clock, idle low, async to clock
//  mosi        in   1  master->slave data, sampled on sck rise
//  miso        out  1  slave->master data, updated on sck fall
//  miso_oe     out  1  1 while read-data phase of a matched read frame
//  wr_pulse    out  1  one-cycle strobe: register written
//  wr_addr     out  8  address of last write
//  wr_data     out  8  data of last write
//  frame_err   out  1  one-cycle strobe: ss released with 1..23 bits
//  host_addr   in   8  local read address
//  host_rdata  out  8  regs[host_addr], 0 if out of range (combinational)
// BEHAVIOUR
//  - Reset: all outputs 0, regs 0, state IDLE.
//  - ss/sck/mosi pass 2-flop synchronisers; sck rise/fall and ss fall/rise detected on sync copies.
//  - Input latency 3 clocks; sck half-period must be >= 4 clocks.
//  - bit_cnt[4:0] counts sck rises in frame; cleared on ss fall; shift_in <= {shift_in[6:0], mosi_s} on each rise.
//  - FSM, IDLE -> ID: on ss fall.
//  - ID -> ADDR: 8th rise; ID==IDW or IDR latches rw (1 = read).
//  - ID -> SKIP: 8th rise with any other ID. SKIP ignores everything until ss rise, with no err and no miso_oe.
//  - ADDR -> DATA: 16th rise latches addr. For a read, shift_out <= (addr<DEPTH) ? regs[addr] : 8'h00.
//  - DATA, write: the 24th rise writes regs[addr] <= shift_in (when addr<DEPTH). It also pulses wr_pulse with wr_addr/wr_data.
//    An out-of-range write drops the data and gives no pulse.
//  - DATA, read: miso_oe=1. Each sck fall drives miso <= shift_out[7], then shift_out <<= 1. 8 falls give bits 7..0.
//  - DATA -> IDLE after the 24th rise; extra bits are ignored until ss rise.
//  - Any state, ss rise: go to IDLE; miso, miso_oe <= 0.
//    1..23 rises counted (bit_cnt !=0, <24) -> frame_err pulse, no write.
//  - ss fall mid-IDLE only; a new frame requires ss high for >= 2 clocks.
//  - Simultaneous host_addr read of a register being written returns the old value that cycle.
//  - Async reset mid-frame aborts silently; the next frame needs a fresh ss fall.
// CONFIGURATION
//  SPI_SLAVE_REGS_STATUS_EN defined:
//   - an 8-bit frame_cnt increments (wrapping 255->0) on every completed matched frame.
//   - A read of addr 8'hFF returns frame_cnt instead of 8'h00.
//   - Writes to 8'hFF are ignored.
//  Not defined: no counter; 8'hFF is treated as any other out-of-range address.
// STRUCTURE
//  Shared package spi_pkg: SLAVE_IDW/IDR defaults, frame length 24, state encodings.
//  Sub-module spi_sync_edge: 2-flop synchroniser plus rise/fall detect, one instance each for ss and sck; mosi uses the synchroniser only.
// TESTING
//  1. Write frame 64/03/A5 -> wr_pulse once, wr_addr=03, wr_data=A5, host_rdata(03)=A5.
//  2. After test 1, read frame 65/03/xx -> miso_oe high for 8 bits; master rdata=A5; no wr_pulse.
//  3. Read 65/20/xx with DEPTH=16 -> rdata=00. Write 64/20/77 -> no wr_pulse, regs unchanged.
//  4. Bad ID 66/03/FF -> no write, miso_oe stays 0, no frame_err, regs[03] unchanged.
//  5. Write 64/05/.. with ss released after 12 bits -> frame_err pulse, regs[05] unchanged; the next full frame succeeds.
//  6. With SPI_SLAVE_REGS_STATUS_EN: 3 good frames and 1 bad ID, then read 65/FF -> 03 (the read itself counts after completion).

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI register target.
package spi_pkg;

  localparam logic [7:0]  SLAVE_IDW_DEF = 8'h64;
  localparam logic [7:0]  SLAVE_IDR_DEF = 8'h65;
  localparam int unsigned ID_END        = 8;
  localparam int unsigned ADDR_END      = 16;
  localparam int unsigned FRAME_BITS    = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID,
    ST_ADDR,
    ST_DATA,
    ST_SKIP
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with rise/fall detect on the synchronised copy.
// Flops reset low so a line already held low across reset never yields a fall.
module spi_sync_edge (
  input  logic clock,
  input  logic n_reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 target for the 24-bit ID/addr/data frame with a byte register file.
// Optional SPI_SLAVE_REGS_STATUS_EN adds a completed-frame counter readable at 8'hFF.
module spi_slave_regs
  import spi_pkg::*;
#(
  parameter logic [7:0]  SLAVE_IDW = SLAVE_IDW_DEF,
  parameter logic [7:0]  SLAVE_IDR = SLAVE_IDR_DEF,
  parameter int unsigned DEPTH     = 16
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic       ss,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       wr_pulse,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  input  logic [7:0] host_addr,
  output logic [7:0] host_rdata
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0]  DEPTH_LIM = 9'(DEPTH);

  function automatic logic in_range(input logic [7:0] a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  function automatic logic [AW-1:0] reg_index(input logic [7:0] a);
    return a[AW-1:0];
  endfunction

  logic ss_rise, ss_fall;
  logic sck_rise, sck_fall;

  spi_sync_edge u_ss_sync (
    .clock   (clock),
    .n_reset (n_reset),
    .din     (ss),
    .rise    (ss_rise),
    .fall    (ss_fall)
  );

  spi_sync_edge u_sck_sync (
    .clock   (clock),
    .n_reset (n_reset),
    .din     (sck),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  logic mosi_meta_q, mosi_meta_d;
  logic mosi_s_q, mosi_s_d;

  always_comb begin
    mosi_meta_d = mosi;
    mosi_s_d    = mosi_meta_q;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      mosi_meta_q <= mosi_meta_d;
      mosi_s_q    <= mosi_s_d;
    end
  end

  spi_state_t state_q;
  logic [4:0] bit_cnt_q;
  logic [7:0] shift_in_q;
  logic [7:0] shift_out_q;
  logic [7:0] addr_q;
  logic       rw_q;
  logic       miso_q;
  logic       miso_oe_q;
  logic       wr_pulse_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic       frame_err_q;
  logic [7:0] regs_q [DEPTH];
`ifdef SPI_SLAVE_REGS_STATUS_EN
  logic [7:0] frame_cnt_q;
`endif

  logic [4:0] cnt_next;
  logic [7:0] shift_next;
  logic [7:0] spi_rdata;
  logic       in_frame;

  always_comb begin
    cnt_next   = bit_cnt_q + 5'd1;
    shift_next = {shift_in_q[6:0], mosi_s_q};
    in_frame   = (state_q == ST_ID) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  end

  // Read data for the SPI side is looked up from the address byte as it completes.
  always_comb begin
    spi_rdata = 8'h00;
    if (in_range(shift_next)) begin
      spi_rdata = regs_q[reg_index(shift_next)];
    end
`ifdef SPI_SLAVE_REGS_STATUS_EN
    else if (shift_next == 8'hFF) begin
      spi_rdata = frame_cnt_q;
    end
`endif
  end

  always_comb begin
    host_rdata = 8'h00;
    if (in_range(host_addr)) begin
      host_rdata = regs_q[reg_index(host_addr)];
    end
`ifdef SPI_SLAVE_REGS_STATUS_EN
    else if (host_addr == 8'hFF) begin
      host_rdata = frame_cnt_q;
    end
`endif
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[AW'(i)] <= '0;
      end
`ifdef SPI_SLAVE_REGS_STATUS_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      wr_pulse_q  <= 1'b0;
      frame_err_q <= 1'b0;
      // ss release wins over any sck edge seen in the same cycle.
      if (ss_rise) begin
        if (in_frame && (bit_cnt_q != 5'd0)) begin
          frame_err_q <= 1'b1;
        end
        state_q   <= ST_IDLE;
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ss_fall) begin
              state_q   <= ST_ID;
              bit_cnt_q <= '0;
            end
          end
          ST_ID: begin
            if (sck_rise) begin
              bit_cnt_q  <= cnt_next;
              shift_in_q <= shift_next;
              if (cnt_next == 5'(ID_END)) begin
                if ((shift_next == SLAVE_IDW) || (shift_next == SLAVE_IDR)) begin
                  rw_q    <= (shift_next == SLAVE_IDR);
                  state_q <= ST_ADDR;
                end else begin
                  state_q <= ST_SKIP;
                end
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              bit_cnt_q  <= cnt_next;
              shift_in_q <= shift_next;
              if (cnt_next == 5'(ADDR_END)) begin
                addr_q  <= shift_next;
                state_q <= ST_DATA;
                if (rw_q) begin
                  shift_out_q <= spi_rdata;
                  miso_oe_q   <= 1'b1;
                end
              end
            end
          end
          ST_DATA: begin
            if (sck_rise) begin
              bit_cnt_q  <= cnt_next;
              shift_in_q <= shift_next;
              if (cnt_next == 5'(FRAME_BITS)) begin
                state_q <= ST_IDLE;
                if (!rw_q && in_range(addr_q)) begin
                  regs_q[reg_index(addr_q)] <= shift_next;
                  wr_pulse_q <= 1'b1;
                  wr_addr_q  <= addr_q;
                  wr_data_q  <= shift_next;
                end
`ifdef SPI_SLAVE_REGS_STATUS_EN
                frame_cnt_q <= frame_cnt_q + 8'd1;
`endif
              end
            end else if (sck_fall && rw_q) begin
              miso_q      <= shift_out_q[7];
              shift_out_q <= {shift_out_q[6:0], 1'b0};
            end
          end
          ST_SKIP: begin
            state_q <= ST_SKIP;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs with a frame-level register model.
module tb_spi_slave_regs;

  localparam int HALF = 6;
  localparam logic [7:0] IDW = 8'h64;
  localparam logic [7:0] IDR = 8'h65;
  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic       ss = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic       wr_pulse;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic [7:0] host_addr = 8'h00;
  logic [7:0] host_rdata;

  int tests = 0;
  int fails = 0;

  logic [7:0]  model_regs [256];
  logic [7:0]  model_cnt = 8'h00;
  logic [15:0] wr_q [$];
  int          err_cnt = 0;
  logic        check_en = 1'b0;

  always #5 clock = ~clock;

  spi_slave_regs #(.SLAVE_IDW(IDW), .SLAVE_IDR(IDR), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .n_reset    (n_reset),
    .ss         (ss),
    .sck        (sck),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .wr_pulse   (wr_pulse),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_err  (frame_err),
    .host_addr  (host_addr),
    .host_rdata (host_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    if (a < DEPTH) return model_regs[a];
`ifdef SPI_SLAVE_REGS_STATUS_EN
    if (a == 8'hFF) return model_cnt;
`endif
    return 8'h00;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Strobe collector plus per-cycle host read port check between frames.
  always @(negedge clock) begin
    if (wr_pulse) wr_q.push_back({wr_addr, wr_data});
    if (frame_err) err_cnt++;
  end

  initial begin
    forever begin
      @(negedge clock);
      if (check_en) begin
        chk("host_rdata", 32'(host_rdata), 32'(model_rd(host_addr)));
        chk("idle_strobes", 32'({wr_pulse, frame_err}), 32'd0);
        host_addr = host_addr + 8'd1;
      end
    end
  end

  task automatic do_reset();
    check_en = 1'b0;
    n_reset = 1'b0;
    ss = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
    model_cnt = 8'h00;
    wait_clk(3);
    n_reset = 1'b1;
    wait_clk(6);
    wr_q.delete();
    err_cnt = 0;
  endtask

  task automatic spi_frame(input logic [23:0] tx, input int nbits, output logic [7:0] rx);
    logic [7:0] id;
    id = tx[23:16];
    rx = 8'h00;
    ss = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[23-i];
      wait_clk(HALF);
      sck = 1'b1;
      chk("miso_oe_bit", 32'(miso_oe), 32'((id == IDR) && (i >= 16)));
      if (i >= 16) rx = {rx[6:0], miso};
      wait_clk(HALF);
      sck = 1'b0;
    end
    wait_clk(HALF);
    ss = 1'b1;
    wait_clk(12);
    chk("miso_oe_after", 32'(miso_oe), 32'd0);
  endtask

  // Runs one frame and checks strobes and read data against the frame-level model.
  task automatic run_frame(input logic [23:0] tx, input int nbits, output logic [7:0] rx);
    logic [7:0] id, a, d, exp_rd;
    logic       matched, exp_wr, exp_err;
    int         err0;
    check_en = 1'b0;
    id = tx[23:16];
    a = tx[15:8];
    d = tx[7:0];
    wr_q.delete();
    err0 = err_cnt;
    spi_frame(tx, nbits, rx);
    matched = (id == IDW) || (id == IDR);
    exp_rd  = model_rd(a);
    exp_wr  = (nbits == 24) && (id == IDW) && (a < DEPTH);
    exp_err = (nbits >= 1) && (nbits < 24) && ((nbits < 8) || matched);
    if (nbits == 24 && matched) model_cnt = model_cnt + 8'd1;
    if (exp_wr) model_regs[a] = d;
    chk("wr_pulse_count", 32'(wr_q.size()), 32'(exp_wr));
    if (exp_wr && wr_q.size() == 1) chk("wr_addr_data", 32'(wr_q[0]), 32'({a, d}));
    chk("frame_err_count", 32'(err_cnt - err0), 32'(exp_err));
    if (nbits == 24 && id == IDR) chk("read_data", 32'(rx), 32'(exp_rd));
    check_en = 1'b1;
    wait_clk(40);
    check_en = 1'b0;
  endtask

  logic [7:0] rx;

  initial begin
    do_reset();
    chk("reset_outputs", 32'({miso, miso_oe, wr_pulse, wr_addr, wr_data, frame_err}), 32'd0);
    host_addr = 8'h03;
    #1;
    chk("reset_reg03", 32'(host_rdata), 32'h00);

    run_frame(24'h6403A5, 24, rx);
    host_addr = 8'h03;
    #1;
    chk("t1_host_rd03", 32'(host_rdata), 32'hA5);
    chk("t1_wr_addr", 32'(wr_addr), 32'h03);
    chk("t1_wr_data", 32'(wr_data), 32'hA5);

    run_frame(24'h650300, 24, rx);
    chk("t2_rdata", 32'(rx), 32'hA5);

    run_frame(24'h652000, 24, rx);
    chk("t3_rdata_oor", 32'(rx), 32'h00);
    run_frame(24'h642077, 24, rx);
    chk("t3_no_pulse", 32'(wr_q.size()), 32'd0);

    run_frame(24'h6603FF, 24, rx);
    host_addr = 8'h03;
    #1;
    chk("t4_reg03_kept", 32'(host_rdata), 32'hA5);

    run_frame(24'h640555, 12, rx);
    chk("t5_err_seen", 32'(err_cnt), 32'd1);
    host_addr = 8'h05;
    #1;
    chk("t5_reg05_kept", 32'(host_rdata), 32'h00);
    run_frame(24'h640555, 24, rx);
    host_addr = 8'h05;
    #1;
    chk("t5_reg05_written", 32'(host_rdata), 32'h55);

    run_frame(24'h640F3C, 24, rx);
    run_frame(24'h641099, 24, rx);
    run_frame(24'h650F00, 24, rx);
    chk("last_reg_rd", 32'(rx), 32'h3C);
    run_frame(24'h650A00, 5, rx);
    run_frame(24'h66AAAA, 10, rx);

    do_reset();
    run_frame(24'h640111, 24, rx);
    run_frame(24'h640222, 24, rx);
    run_frame(24'h650100, 24, rx);
    chk("t6_rd01", 32'(rx), 32'h11);
    run_frame(24'h660100, 24, rx);
    run_frame(24'h64FF12, 24, rx);
    run_frame(24'h65FF00, 24, rx);
`ifdef SPI_SLAVE_REGS_STATUS_EN
    chk("t6_frame_cnt", 32'(rx), 32'h04);
`else
    chk("t6_ff_zero", 32'(rx), 32'h00);
`endif

    do_reset();
    run_frame(24'h640000, 0, rx);
    run_frame(24'h65FF00, 24, rx);
`ifdef SPI_SLAVE_REGS_STATUS_EN
    chk("t6_spec_cnt", 32'(rx), 32'h00);
`else
    chk("t6_spec_ff", 32'(rx), 32'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
